// File: rtl/mux4_scan_sequencer_if.sv
// Bundle of control, sample and result signals between the scan sequencer
// and whatever drives it and feeds it the multiplexer output.
//
// Signals:
//   start       begin a scan (sampled only while the sequencer is idle)
//   cont        1 = continuous scanning, 0 = single-shot
//   abort       synchronous abort of the scan in progress
//   mux_out     output of the 4:1 multiplexer being scanned
//   s1, s0      registered multiplexer selects
//   busy        high while a scan is in progress
//   frame       last completed 4-bit frame, frame[k] sampled with {s1,s0}=k
//   frame_valid one-cycle pulse when frame updates
//
// Modports: master drives start/cont/abort/mux_out, slave is the sequencer.
interface mux4_scan_sequencer_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       mux_out;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;

  modport master (
    output start, cont, abort, mux_out,
    input  s1, s0, busy, frame, frame_valid
  );

  modport slave (
    input  start, cont, abort, mux_out,
    output s1, s0, busy, frame, frame_valid
  );
endinterface

// File: rtl/mux4_scan_sequencer.sv
// Upstream control stage for a 4:1 multiplexer. Steps the selects through
// channels 0..3, dwells DWELL cycles on each, samples the multiplexer output
// once per channel and publishes the four samples as a frame with a
// one-cycle frame_valid pulse. Single-shot or continuous, with abort.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mux4_scan_sequencer_if (start, cont, abort,
//          mux_out in; s1, s0, busy, frame, frame_valid out, all registered)
//
// Parameters:
//   DWELL  cycles spent on each channel before sampling, 1..255
//   CNT_W  dwell counter width, DWELL <= 2^CNT_W - 1
module mux4_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mux4_scan_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       sel_r;
  logic [2:0]       shadow_r;
  logic [3:0]       frame_r;
  logic             frame_valid_r;
  logic             busy_r;

  // Scan FSM: select stepping, dwell counting, sampling and frame assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      sel_r         <= 2'd0;
      shadow_r      <= 3'b000;
      frame_r       <= 4'b0000;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // frame_valid is a pulse: cleared every edge unless a frame completes.
      frame_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sel_r <= 2'd0;
          cnt_r <= '0;
          // start wins over a simultaneous abort here; abort only acts in SCAN.
          if (bus.start) begin
            state_r <= SCAN;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.abort) begin
            // Partial frame is dropped; frame keeps its previous value.
            state_r <= IDLE;
            sel_r   <= 2'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (cnt_r < CNT_LAST) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            cnt_r <= '0;
            case (sel_r)
              2'd0: begin
                shadow_r[0] <= bus.mux_out;
                sel_r       <= 2'd1;
              end
              2'd1: begin
                shadow_r[1] <= bus.mux_out;
                sel_r       <= 2'd2;
              end
              2'd2: begin
                shadow_r[2] <= bus.mux_out;
                sel_r       <= 2'd3;
              end
              default: begin
                // Last channel: the live sample joins the three held ones.
                frame_r       <= {bus.mux_out, shadow_r};
                frame_valid_r <= 1'b1;
                sel_r         <= 2'd0;
                // cont is only consulted here, so mid-frame changes wait.
                if (!bus.cont) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                end else begin
                  state_r <= SCAN;
                end
              end
            endcase
          end
        end
        default: begin
          state_r <= IDLE;
          sel_r   <= 2'd0;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1          = sel_r[1];
  assign bus.s0          = sel_r[0];
  assign bus.busy        = busy_r;
  assign bus.frame       = frame_r;
  assign bus.frame_valid = frame_valid_r;

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed bench for mux4_scan_sequencer: a DWELL=4 instance and a DWELL=1
// instance, each fed by a combinational 4:1 multiplexer model over in4
// (in4[k] is multiplexer input ik).
module tb_mux4_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] in4;
  logic [1:0] seltrace [0:19];

  int n_checks;
  int n_fail;

  mux4_scan_sequencer_if b4 ();
  mux4_scan_sequencer_if b1 ();

  assign b4.mux_out = in4[{b4.s1, b4.s0}];
  assign b1.mux_out = in4[{b1.s1, b1.s0}];

  mux4_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  mux4_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       i0, i1, i2, i3;
    logic [3:0] exp_frame;
  } vec_t;

  vec_t vecs [0:5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_fv(input bit d1);
    return d1 ? b1.frame_valid : b4.frame_valid;
  endfunction

  function automatic logic [1:0] get_sel(input bit d1);
    return d1 ? {b1.s1, b1.s0} : {b4.s1, b4.s0};
  endfunction

  task automatic drive_start(input bit d1, input logic v);
    if (d1) b1.start = v;
    else    b4.start = v;
  endtask

  // Pulse start, then count edges after the start edge until frame_valid.
  // Optionally re-pulses start at edge count 'repulse'. Bounded at 100.
  task automatic run_frame(input bit d1, input int repulse, output int lat);
    lat = 0;
    drive_start(d1, 1'b1);
    @(posedge clk); #1;
    drive_start(d1, 1'b0);
    b4.abort = 1'b0;
    seltrace[0] = get_sel(d1);
    while (!get_fv(d1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 20) seltrace[lat] = get_sel(d1);
      drive_start(d1, (lat == repulse) ? 1'b1 : 1'b0);
    end
    drive_start(d1, 1'b0);
  endtask

  int         lat;
  int         nfv;
  int         fvt [0:3];
  logic [3:0] fvf [0:3];
  logic [3:0] frame_before;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    in4      = 4'b0000;
    b4.start = 1'b0; b4.cont = 1'b0; b4.abort = 1'b0;
    b1.start = 1'b0; b1.cont = 1'b0; b1.abort = 1'b0;

    vecs[0] = '{"ss_1011", 1'b1, 1'b0, 1'b1, 1'b1, 4'b1101};
    vecs[1] = '{"ss_0000", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2] = '{"ss_1111", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111};
    vecs[3] = '{"ss_0110", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110};
    vecs[4] = '{"ss_1000", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[5] = '{"ss_0001", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000};

    // Reset state
    rst_n = 1'b0;
    #12;
    check("reset_sel",   {30'd0, b4.s1, b4.s0}, 32'd0);
    check("reset_busy",  {31'd0, b4.busy}, 32'd0);
    check("reset_frame", {28'd0, b4.frame}, 32'd0);
    check("reset_fv",    {31'd0, b4.frame_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-shot table, DWELL=4
    for (int v = 0; v < 6; v++) begin
      in4 = {vecs[v].i3, vecs[v].i2, vecs[v].i1, vecs[v].i0};
      run_frame(1'b0, -1, lat);
      check({vecs[v].name, "_lat"},   lat, 32'd16);
      check({vecs[v].name, "_frame"}, {28'd0, b4.frame}, {28'd0, vecs[v].exp_frame});
      @(posedge clk); #1;
      check({vecs[v].name, "_idle"},  {30'd0, b4.busy, b4.frame_valid}, 32'd0);
      if (v == 0) begin
        // Select stepping every 4 cycles from the first run
        check("sel_t3",  {30'd0, seltrace[3]},  32'd0);
        check("sel_t4",  {30'd0, seltrace[4]},  32'd1);
        check("sel_t8",  {30'd0, seltrace[8]},  32'd2);
        check("sel_t12", {30'd0, seltrace[12]}, 32'd3);
        check("sel_t15", {30'd0, seltrace[15]}, 32'd3);
      end
    end

    // Continuous mode with i2 dropping mid second frame, then cont cleared
    in4 = 4'b0110;
    b4.cont = 1'b1;
    nfv = 0;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 20) in4[2] = 1'b0;
      if (c == 36) b4.cont = 1'b0;
      if (b4.frame_valid) begin
        if (nfv < 4) begin
          fvt[nfv] = c;
          fvf[nfv] = b4.frame;
        end
        nfv++;
      end
    end
    check("cont_nfv",    nfv, 32'd3);
    check("cont_t0",     fvt[0], 32'd16);
    check("cont_t1",     fvt[1], 32'd32);
    check("cont_t2",     fvt[2], 32'd48);
    check("cont_f0",     {28'd0, fvf[0]}, 32'h6);
    check("cont_f1",     {28'd0, fvf[1]}, 32'h2);
    check("cont_f2",     {28'd0, fvf[2]}, 32'h2);
    check("cont_busy",   {31'd0, b4.busy}, 32'd0);

    // Abort at cycle 9 (sel=2)
    frame_before = b4.frame;
    in4 = 4'b1111;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
    end
    check("abort_sel_before", {30'd0, b4.s1, b4.s0}, 32'd2);
    b4.abort = 1'b1;
    @(posedge clk); #1;
    b4.abort = 1'b0;
    check("abort_busy",  {31'd0, b4.busy}, 32'd0);
    check("abort_sel",   {30'd0, b4.s1, b4.s0}, 32'd0);
    check("abort_fv",    {31'd0, b4.frame_valid}, 32'd0);
    check("abort_frame", {28'd0, b4.frame}, {28'd0, frame_before});
    nfv = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (b4.frame_valid) nfv++;
    end
    check("abort_no_fv", nfv, 32'd0);

    // DWELL=1 instance
    in4 = 4'b0011;
    run_frame(1'b1, -1, lat);
    check("d1_lat",   lat, 32'd4);
    check("d1_frame", {28'd0, b1.frame}, 32'h3);
    @(posedge clk); #1;
    check("d1_idle",  {30'd0, b1.busy, b1.frame_valid}, 32'd0);

    // start re-pulsed while busy
    in4 = 4'b1010;
    run_frame(1'b0, 5, lat);
    check("repulse_lat",   lat, 32'd16);
    check("repulse_frame", {28'd0, b4.frame}, 32'hA);
    @(posedge clk); #1;
    check("repulse_idle",  {31'd0, b4.busy}, 32'd0);

    // start and abort together in IDLE
    in4 = 4'b0100;
    b4.abort = 1'b1;
    run_frame(1'b0, -1, lat);
    check("start_abort_lat",   lat, 32'd16);
    check("start_abort_frame", {28'd0, b4.frame}, 32'h4);
    @(posedge clk); #1;

    // Async reset mid-scan
    in4 = 4'b0101;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_sel",   {30'd0, b4.s1, b4.s0}, 32'd0);
    check("areset_busy",  {31'd0, b4.busy}, 32'd0);
    check("areset_frame", {28'd0, b4.frame}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, -1, lat);
    check("post_reset_lat",   lat, 32'd16);
    check("post_reset_frame", {28'd0, b4.frame}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
